// File: rtl/sigreplay_pkg.sv
// Shared types for the record-and-playback buffer.
package sigreplay_pkg;

    // Controller states: waiting, capturing samples, replaying the clip.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

endpackage : sigreplay_pkg

// File: rtl/sigreplay_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// 1-cycle read latency. The read register resets to 0 and holds its value on
// cycles without a read, so it can drive a "hold last sample" output directly.
module ram
    import sigreplay_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en
);

    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= din;
        end
    end

    // Read data register; updates only when a read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign dout = rd_data_r;

endmodule : ram

// File: rtl/sigreplay.sv
// Record-and-playback buffer for the microphone sample stream. Captures
// samples while rec is held, replays the clip once or in a loop on play.
module sigreplay
    import sigreplay_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rec,
    input  logic                  play,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [DATA_WIDTH-1:0] mic_signal,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   rec_len,
    output logic                  full,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_r, wr_ptr_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_r, rd_ptr_s;
    logic [ADDR_WIDTH:0]   rec_len_r, rec_len_s;
    logic                  full_r, full_s;
    logic                  armed_r, armed_s;   // rec seen low since last capacity stop
    logic                  busy_r;
    logic                  dout_valid_r;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [ADDR_WIDTH:0]   last_idx_s;
    logic [DATA_WIDTH-1:0] ram_dout_s;

    // Index of the final recorded sample, kept at full count width so that a
    // 2^ADDR_WIDTH clip still compares correctly.
    assign last_idx_s = rec_len_r - LEN_ONE;

    // Next-state and datapath control for the record/play controller.
    always_comb begin
        state_s   = state_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        rec_len_s = rec_len_r;
        full_s    = full_r;
        armed_s   = armed_r;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;

        if (!rec) begin
            armed_s = 1'b1;
        end else begin
            armed_s = armed_r;
        end

        case (state_r)
            IDLE: begin
                if (rec && armed_r) begin
                    state_s   = RECORD;
                    wr_ptr_s  = PTR_ZERO;
                    rec_len_s = LEN_ZERO;
                    full_s    = 1'b0;
                end else if (play && !rec && (rec_len_r != LEN_ZERO)) begin
                    state_s  = PLAY;
                    rd_ptr_s = PTR_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end

            RECORD: begin
                if (!rec) begin
                    state_s = IDLE;
                end else if (en) begin
                    wr_en_s   = 1'b1;
                    wr_ptr_s  = wr_ptr_r + PTR_ONE;
                    rec_len_s = rec_len_r + LEN_ONE;
                    if (wr_ptr_r == LAST_ADDR) begin
                        // Capacity reached: stop and require rec to go low
                        // before another capture may start.
                        state_s = IDLE;
                        full_s  = 1'b1;
                        armed_s = 1'b0;
                    end else begin
                        state_s = RECORD;
                    end
                end else begin
                    state_s = RECORD;
                end
            end

            PLAY: begin
                if (stop) begin
                    // Any read in this cycle is dropped so no valid follows.
                    state_s = IDLE;
                end else if (en) begin
                    rd_en_s = 1'b1;
                    if ({1'b0, rd_ptr_r} == last_idx_s) begin
                        if (loop) begin
                            rd_ptr_s = PTR_ZERO;
                            state_s  = PLAY;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        rd_ptr_s = rd_ptr_r + PTR_ONE;
                        state_s  = PLAY;
                    end
                end else begin
                    state_s = PLAY;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pointers, status flags and the output valid register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            rec_len_r    <= LEN_ZERO;
            full_r       <= 1'b0;
            armed_r      <= 1'b1;
            busy_r       <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            rec_len_r    <= rec_len_s;
            full_r       <= full_s;
            armed_r      <= armed_s;
            busy_r       <= (state_s != IDLE);
            dout_valid_r <= rd_en_s;
        end
    end

    ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_ptr_r),
        .din     (mic_signal),
        .wr_en   (wr_en_s),
        .rd_addr (rd_ptr_r),
        .dout    (ram_dout_s),
        .rd_en   (rd_en_s)
    );

    assign dout       = ram_dout_s;
    assign dout_valid = dout_valid_r;
    assign rec_len    = rec_len_r;
    assign full       = full_r;
    assign busy       = busy_r;

endmodule : sigreplay

// File: tb/tb_sigreplay.sv
// Self-checking bench for sigreplay. The reference model is the list of
// samples captured (a queue) and the replay order derived from it.
module tb_sigreplay;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rec;
    logic          play;
    logic          stop;
    logic          loop;
    logic [DW-1:0] mic_signal;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW:0]   rec_len;
    logic          full;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] clip[$];   // samples the bench expects to be stored
    logic [DW-1:0] got[$];    // samples observed with dout_valid

    sigreplay #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rec        (rec),
        .play       (play),
        .stop       (stop),
        .loop       (loop),
        .mic_signal (mic_signal),
        .dout       (dout),
        .dout_valid (dout_valid),
        .rec_len    (rec_len),
        .full       (full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (dout_valid === 1'b1) got.push_back(dout);
    endtask

    // Capture the contents of clip with 'gap' idle cycles before each strobe.
    task automatic record_clip(input int gap);
        rec = 1'b1; en = 1'b0; tick();
        foreach (clip[i]) begin
            repeat (gap) begin en = 1'b0; mic_signal = DW'($urandom); tick(); end
            en = 1'b1; mic_signal = clip[i]; tick();
        end
        en = 1'b0; rec = 1'b0; tick();
    endtask

    // Pulse play, then hold en until busy drops or the bound expires.
    task automatic play_collect(input int bound, output bit timed_out);
        int n;
        got.delete();
        play = 1'b1; en = 1'b0; tick();
        play = 1'b0; en = 1'b1; n = 0;
        do begin tick(); n++; end while (busy === 1'b1 && n < bound);
        en = 1'b0;
        timed_out = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rec = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0;
        mic_signal = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dout_valid); end
        checks++; if (rec_len !== 9'd0) begin errors++; $display("FAIL reset_rec_len got %0d want 0", rec_len); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        clip.delete();
        for (int i = 1; i <= 5; i++) clip.push_back(DW'(i * 10));
        record_clip(0);
        checks++; if (rec_len !== 9'd5) begin errors++; $display("FAIL basic_rec_len got %0d want 5", rec_len); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL basic_full got %0b want 0", full); end
        play_collect(20, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout busy still %0b", busy); end
        checks++; if (dout_valid !== 1'b1 || dout !== 8'd50) begin errors++;
            $display("FAIL basic_last_with_busy_drop got valid=%0b dout=%0d want 1/50", dout_valid, dout); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL basic_count got %0d want 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== clip[i]) begin errors++; $display("FAIL basic_sample[%0d] got %0d want %0d", i, got[i], clip[i]); end
        end
        tick();
        checks++; if (dout_valid !== 1'b0 || dout !== 8'd50) begin errors++;
            $display("FAIL basic_hold got valid=%0b dout=%0d want 0/50", dout_valid, dout); end
    endtask

    task automatic test_loop();
        got.delete();
        loop = 1'b1;
        play = 1'b1; en = 1'b0; tick();
        play = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL loop_gap cycle %0d got valid=%0b want 1", i, dout_valid); end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL loop_stop_valid got %0b want 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy got %0b want 0", busy); end
        repeat (3) tick();
        en = 1'b0; loop = 1'b0;
        checks++; if (got.size() != 12) begin errors++; $display("FAIL loop_count got %0d want 12", got.size()); end
        for (int i = 0; i < got.size() && i < 12; i++) begin
            checks++; if (got[i] !== clip[i % 5]) begin errors++; $display("FAIL loop_sample[%0d] got %0d want %0d", i, got[i], clip[i % 5]); end
        end
    endtask

    task automatic test_full();
        bit to;
        clip.delete();
        for (int i = 0; i < 256; i++) clip.push_back(DW'(i));
        rec = 1'b1; en = 1'b0; tick();
        for (int i = 0; i < 260; i++) begin
            en = 1'b1; mic_signal = DW'(i + 100 * (i / 256)); tick();
            if (i == 255) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", full); end
                checks++; if (rec_len !== 9'd256) begin errors++; $display("FAIL full_rec_len got %0d want 256", rec_len); end
            end
            if (i >= 255) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_no_reentry cycle %0d got busy=%0b want 0", i, busy); end
            end
        end
        rec = 1'b0; en = 1'b0; tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_sticky got %0b want 1", full); end
        play_collect(300, to);
        checks++; if (to) begin errors++; $display("FAIL full_timeout busy still %0b", busy); end
        checks++; if (got.size() != 256) begin errors++; $display("FAIL full_count got %0d want 256", got.size()); end
        for (int i = 0; i < got.size() && i < 256; i++) begin
            checks++; if (got[i] !== clip[i]) begin errors++; $display("FAIL full_sample[%0d] got %0d want %0d", i, got[i], clip[i]); end
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        int n;
        clip.delete();
        for (int i = 0; i < 4; i++) clip.push_back(DW'($urandom));
        got.delete();
        rec = 1'b1; play = 1'b1; en = 1'b0; tick();
        play = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_enter_record got busy=%0b want 1", busy); end
        foreach (clip[i]) begin en = 1'b1; mic_signal = clip[i]; tick(); end
        rec = 1'b0; en = 1'b0; tick();
        checks++; if (got.size() != 0) begin errors++; $display("FAIL simul_no_play got %0d samples want 0", got.size()); end
        checks++; if (rec_len !== 9'd4) begin errors++; $display("FAIL simul_rec_len got %0d want 4", rec_len); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full_cleared got %0b want 0", full); end
        // rec asserted mid-play must not disturb playback
        got.delete();
        play = 1'b1; tick(); play = 1'b0; en = 1'b1;
        tick();
        rec = 1'b1; tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_rec_in_play got busy=%0b want 1", busy); end
        rec = 1'b0; n = 0;
        do begin tick(); n++; end while (busy === 1'b1 && n < 20);
        en = 1'b0;
        to = (busy !== 1'b0);
        checks++; if (to) begin errors++; $display("FAIL simul_timeout busy still %0b", busy); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL simul_count got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== clip[i]) begin errors++; $display("FAIL simul_sample[%0d] got %0d want %0d", i, got[i], clip[i]); end
        end
        checks++; if (rec_len !== 9'd4) begin errors++; $display("FAIL simul_len_kept got %0d want 4", rec_len); end
    endtask

    task automatic test_reset_mid_play();
        clip.delete();
        for (int i = 0; i < 5; i++) clip.push_back(DW'($urandom_range(1, 255)));
        record_clip(0);
        got.delete();
        play = 1'b1; en = 1'b0; tick(); play = 1'b0; en = 1'b1;
        tick(); tick();
        checks++; if (dout_valid !== 1'b1 || dout !== clip[1]) begin errors++;
            $display("FAIL rstmid_pre got valid=%0b dout=%0d want 1/%0d", dout_valid, dout, clip[1]); end
        #1 rst = 1'b1;
        #1;
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL rstmid_dout got %0d want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", dout_valid); end
        checks++; if (rec_len !== 9'd0) begin errors++; $display("FAIL rstmid_rec_len got %0d want 0", rec_len); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %0b want 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        @(posedge clk); #1 rst = 1'b0; en = 1'b0;
        play = 1'b1; tick(); play = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_play_ignored got busy=%0b want 0", busy); end
        en = 1'b1; tick(); en = 1'b0;
        checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_idle got valid=%0b busy=%0b want 0/0", dout_valid, busy); end
    endtask

    task automatic test_sparse();
        int len;
        int k;
        len = 4 + int'($urandom_range(0, 4));
        clip.delete();
        for (int i = 0; i < len; i++) clip.push_back(DW'($urandom));
        rec = 1'b1; en = 1'b0; tick();
        for (int i = 0; i < len; i++) begin
            repeat (2) begin en = 1'b0; mic_signal = DW'($urandom); tick(); end
            en = 1'b1; mic_signal = clip[i]; tick();
            checks++; if (rec_len !== (AW+1)'(i + 1)) begin errors++; $display("FAIL sparse_rec_len got %0d want %0d", rec_len, i + 1); end
        end
        rec = 1'b0; en = 1'b0; tick();
        got.delete();
        play = 1'b1; tick(); play = 1'b0;
        k = 0;
        while (got.size() < len && k < 200) begin
            en = (k % 3 == 2) ? 1'b1 : 1'b0;
            tick();
            checks++; if (dout_valid !== en) begin errors++; $display("FAIL sparse_valid_timing cycle %0d got %0b want %0b", k, dout_valid, en); end
            k++;
        end
        en = 1'b0;
        checks++; if (k >= 200) begin errors++; $display("FAIL sparse_timeout got %0d samples want %0d", got.size(), len); end
        for (int i = 0; i < got.size() && i < len; i++) begin
            checks++; if (got[i] !== clip[i]) begin errors++; $display("FAIL sparse_sample[%0d] got %0d want %0d", i, got[i], clip[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sparse_end_busy got %0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_full();
        test_simultaneous();
        test_reset_mid_play();
        test_sparse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule : tb_sigreplay
